// File: rtl/i2s_pkg.sv
// Shared I2S types: default sample width, stereo frame layout, FIFO fill classification.
package i2s_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] left;
        logic [WIDTH_DEFAULT-1:0] right;
    } stereo_sample_t;

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} fill_state_e;

    // Occupancy class of a sample buffer, derived purely from its entry count.
    function automatic fill_state_e fill_state(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return StEmpty;
        end else if (count >= depth) begin
            return StFull;
        end
        return StPartial;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port. Contents are not reset.
module sample_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          sclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write the incoming frame on the clock edge.
    always_ff @(posedge sclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_rx_sample_fifo.sv
// Stereo frame FIFO between the I2S receiver and the DSP stage. First-word fall-through with a
// registered head, sticky overflow flag and occupancy count. Everything runs on sclk.
module i2s_rx_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic                     frame_stb_i,
    input  logic [WIDTH-1:0]         left_i,
    input  logic [WIDTH-1:0]         right_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         left_o,
    output logic [WIDTH-1:0]         right_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] next_head;
    fill_state_e   fill_st;
    logic          pop, wr, drop;

    assign fill_st     = fill_state(32'(count_q), DEPTH);
    assign out_valid_o = (fill_st != StEmpty);
    assign full_o      = (fill_st == StFull);
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;
    assign left_o      = head_q[DW-1:WIDTH];
    assign right_o     = head_q[WIDTH-1:0];

    // A full FIFO still accepts a frame when the head leaves on the same edge.
    assign pop  = out_valid_o & out_ready_i;
    assign wr   = frame_stb_i & (!full_o | pop);
    assign drop = frame_stb_i & full_o & !pop;

    sample_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .sclk  (sclk),
        .we    (wr),
        .waddr (wr_ptr_q),
        .wdata ({left_i, right_i}),
        .raddr (rd_ptr_q + AW'(1)),
        .rdata (next_head)
    );

    // Next-state for pointers, count, overflow flag and the registered head entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        ovf_d    = ovf_q;

        if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !wr) begin
            count_d = count_q - (AW + 1)'(1);
        end

        // Head takes the incoming frame when it becomes the only entry; otherwise the successor.
        if (wr && (count_q == '0 || (count_q == (AW + 1)'(1) && pop))) begin
            head_d = {left_i, right_i};
        end else if (pop && count_q >= (AW + 1)'(2)) begin
            head_d = next_head;
        end

        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    // Only reachable if DEPTH were overridden illegally; keeps the count width honest.
    logic unused_depth;
    assign unused_depth = ^DEPTH_CNT;

endmodule

// File: tb/tb_i2s_rx_sample_fifo.sv
// Directed bench for the I2S receive sample FIFO.
module tb_i2s_rx_sample_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    logic              sclk;
    logic              rst;
    logic              frame_stb_i;
    logic [WIDTH-1:0]  left_i, right_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WIDTH-1:0]  left_o, right_o;
    logic [3:0]        count_o;
    logic              full_o;
    logic              ovf_o;
    logic              ovf_clr_i;

    int n_cmp = 0;
    int n_bad = 0;

    i2s_rx_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .frame_stb_i (frame_stb_i),
        .left_i      (left_i),
        .right_i     (right_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .left_o      (left_o),
        .right_o     (right_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        frame_stb_i = 1'b1;
        left_i      = l;
        right_i     = r;
        tick();
        frame_stb_i = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] l, input logic [15:0] r);
        check({tag, " valid"}, 32'(out_valid_o), 32'd1);
        check({tag, " left"}, 32'(left_o), 32'(l));
        check({tag, " right"}, 32'(right_o), 32'(r));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic fill_n();
        for (int n = 0; n < 8; n++) begin
            push(16'(n) << 8, (16'(n) << 8) | 16'h0001);
        end
    endtask

    initial begin
        rst         = 1'b0;
        frame_stb_i = 1'b0;
        left_i      = '0;
        right_i     = '0;
        out_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;

        // Reset state.
        repeat (5) tick();
        check("rst count", 32'(count_o), 32'd0);
        check("rst valid", 32'(out_valid_o), 32'd0);
        check("rst ovf", 32'(ovf_o), 32'd0);
        check("rst full", 32'(full_o), 32'd0);
        check("rst left", 32'(left_o), 32'h0000);
        check("rst right", 32'(right_o), 32'h0000);
        rst = 1'b1;
        tick();

        // Single frame, one-edge fall-through latency.
        push(16'hdead, 16'hbeef);
        check("single count", 32'(count_o), 32'd1);
        pop_expect("single", 16'hdead, 16'hbeef);
        check("single empty valid", 32'(out_valid_o), 32'd0);
        check("single empty count", 32'(count_o), 32'd0);
        check("empty holds left", 32'(left_o), 32'hdead);

        // Fill and drain three times to wrap both pointers.
        for (int rep = 0; rep < 3; rep++) begin
            fill_n();
            check("fill full", 32'(full_o), 32'd1);
            check("fill count", 32'(count_o), 32'd8);
            for (int n = 0; n < 8; n++) begin
                pop_expect("drain", 16'(n) << 8, (16'(n) << 8) | 16'h0001);
            end
            check("drain count", 32'(count_o), 32'd0);
        end

        // Overflow: dropped frame, sticky flag, clear, and set winning over clear.
        fill_n();
        push(16'h1234, 16'h5678);
        check("ovf flag", 32'(ovf_o), 32'd1);
        check("ovf count", 32'(count_o), 32'd8);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("ovf cleared", 32'(ovf_o), 32'd0);
        ovf_clr_i = 1'b1;
        push(16'h1234, 16'h5678);
        ovf_clr_i = 1'b0;
        check("ovf set wins", 32'(ovf_o), 32'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        for (int n = 0; n < 8; n++) begin
            pop_expect("ovf drain", 16'(n) << 8, (16'(n) << 8) | 16'h0001);
        end
        check("ovf drain count", 32'(count_o), 32'd0);

        // Full with simultaneous write and pop.
        fill_n();
        out_ready_i = 1'b1;
        push(16'haaaa, 16'h5555);
        out_ready_i = 1'b0;
        check("wp count", 32'(count_o), 32'd8);
        check("wp ovf", 32'(ovf_o), 32'd0);
        check("wp full", 32'(full_o), 32'd1);
        for (int n = 1; n < 8; n++) begin
            pop_expect("wp drain", 16'(n) << 8, (16'(n) << 8) | 16'h0001);
        end
        pop_expect("wp last", 16'haaaa, 16'h5555);
        check("wp empty", 32'(count_o), 32'd0);

        // Single entry with simultaneous write and pop: head advances to the new frame.
        push(16'h1111, 16'h2222);
        out_ready_i = 1'b1;
        push(16'h3333, 16'h4444);
        out_ready_i = 1'b0;
        check("one wp count", 32'(count_o), 32'd1);
        pop_expect("one wp head", 16'h3333, 16'h4444);

        // Asynchronous reset mid-drain empties the FIFO at once; release mid-cycle.
        push(16'h0a0a, 16'h0b0b);
        push(16'h0c0c, 16'h0d0d);
        push(16'h0e0e, 16'h0f0f);
        pop_expect("pre rst", 16'h0a0a, 16'h0b0b);
        rst = 1'b0;
        #1;
        check("async rst count", 32'(count_o), 32'd0);
        check("async rst valid", 32'(out_valid_o), 32'd0);
        check("async rst left", 32'(left_o), 32'h0000);
        #2;
        rst = 1'b1;
        tick();
        check("post rst count", 32'(count_o), 32'd0);
        push(16'hdead, 16'hbeef);
        pop_expect("post rst frame", 16'hdead, 16'hbeef);
        check("post rst empty", 32'(count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
